// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM state and SPI mode definitions
package spi_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} spi_state_e;

    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_ACTIVE = ACTIVE;

    localparam int CPOL_IDLE_LOW  = 0;
    localparam int CPOL_IDLE_HIGH = 1;
    localparam int CPHA_LEADING   = 0;
    localparam int CPHA_TRAILING  = 1;

    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return ((cpol ^ cpha) & 1) == 0;
    endfunction
endpackage

// File: rtl/spi_slave_sync_if.sv
// rtl/spi_slave_sync_if.sv - parallel word handshake bundle of the SPI slave
interface spi_slave_sync_if #(parameter int WIDTH = 64);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    modport slave  (input tx_data, tx_valid, rx_ready, output tx_ready, rx_data, rx_valid);
    modport master (output tx_data, tx_valid, rx_ready, input tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - two-flop synchroniser with per-bit idle reset level
module spi_sync #(
    parameter int             WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - oversampled SPI slave with word handshakes on the system clock
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CPOL  = 0,
    parameter int CPHA  = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    output logic overrun,
    output logic underrun,
    output logic frame_err,
    spi_slave_sync_if.slave bus
);
    localparam int               CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam bit               SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
    localparam logic [2:0]       SYNC_RST    = {1'(CPOL), 1'b1, 1'b0};

    logic [2:0]       w_sync;
    logic             r_sclk_d, r_cs_d;
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rx_shift, r_rx_data, r_tx_shift, r_tx_buf;
    logic             r_rx_valid, r_tx_full, r_miso, r_loaded, r_pend, r_pend_full;
    logic             r_overrun, r_underrun, r_frame_err;

    spi_sync #(.WIDTH(3), .RESET_VAL(SYNC_RST)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d ({sclk, cs_n, mosi}),
        .o_q (w_sync)
    );

    logic w_sclk_s, w_cs_s, w_mosi_s;
    assign {w_sclk_s, w_cs_s, w_mosi_s} = w_sync;

    logic w_rise, w_fall, w_active, w_start, w_stop, w_samp, w_shift, w_word_done;
    assign w_rise      = w_sclk_s & ~r_sclk_d;
    assign w_fall      = ~w_sclk_s & r_sclk_d;
    assign w_active    = (r_state == ST_ACTIVE);
    assign w_start     = !w_active && r_cs_d && !w_cs_s;
    assign w_stop      = w_active && !r_cs_d && w_cs_s;
    assign w_samp      = w_active && !w_stop && (SAMPLE_RISE ? w_rise : w_fall);
    assign w_shift     = w_active && !w_stop && (SAMPLE_RISE ? w_fall : w_rise);
    assign w_word_done = w_samp && (r_cnt == LAST_BIT);

    // A word-boundary load in CPHA=0 lands on the edge that also ends a frame, so its
    // buffer consumption is only committed once the next word really starts sampling.
    logic             w_reload, w_commit_now, w_commit, w_commit_full;
    logic [WIDTH-1:0] w_load_data, w_rx_next;
    assign w_reload      = w_shift && !r_loaded;
    assign w_load_data   = r_tx_full ? r_tx_buf : '0;
    assign w_commit_now  = w_start || (w_reload && (CPHA != CPHA_LEADING));
    assign w_commit      = w_commit_now || (w_samp && r_pend);
    assign w_commit_full = w_commit_now ? r_tx_full : r_pend_full;
    assign w_rx_next     = {r_rx_shift[WIDTH-2:0], w_mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_d    <= 1'(CPOL);
            r_cs_d      <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_shift  <= '0;
            r_tx_buf    <= '0;
            r_tx_full   <= 1'b0;
            r_miso      <= 1'b0;
            r_loaded    <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_full <= 1'b0;
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
            r_overrun   <= 1'b0;
            r_underrun  <= w_commit && !w_commit_full;
            r_frame_err <= 1'b0;

            if (w_start)     r_state <= ST_ACTIVE;
            else if (w_stop) r_state <= ST_IDLE;

            if (bus.tx_valid && !r_tx_full) begin
                r_tx_buf  <= bus.tx_data;
                r_tx_full <= 1'b1;
            end else if (w_commit && w_commit_full) begin
                r_tx_full <= 1'b0;
            end

            if (w_start) begin
                r_tx_shift <= w_load_data;
                r_miso     <= 1'b0;
            end else if (w_reload) begin
                r_tx_shift <= (CPHA != CPHA_LEADING) ? (w_load_data << 1) : w_load_data;
                r_miso     <= w_load_data[WIDTH-1];
            end else if (w_shift) begin
                r_tx_shift <= r_tx_shift << 1;
                r_miso     <= r_tx_shift[WIDTH-1];
            end

            if (w_start || w_reload)         r_loaded <= 1'b1;
            else if (w_word_done || w_stop)  r_loaded <= 1'b0;

            if (w_reload && (CPHA == CPHA_LEADING)) begin
                r_pend      <= 1'b1;
                r_pend_full <= r_tx_full;
            end else if (w_stop || w_samp) begin
                r_pend <= 1'b0;
            end

            if (w_stop) begin
                r_frame_err <= (r_cnt != '0);
                r_cnt       <= '0;
                r_rx_shift  <= '0;
            end else if (w_samp) begin
                r_rx_shift <= w_rx_next;
                r_cnt      <= w_word_done ? '0 : r_cnt + 1'b1;
            end

            if (w_word_done) begin
                if (!r_rx_valid || bus.rx_ready) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign miso         = w_active ? ((CPHA != CPHA_LEADING) ? r_miso : r_tx_shift[WIDTH-1]) : 1'b0;
    assign miso_oe      = w_active;
    assign bus.tx_ready = !r_tx_full;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign overrun      = r_overrun;
    assign underrun     = r_underrun;
    assign frame_err    = r_frame_err;
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb/tb_spi_slave_sync.sv - directed bench: 64-bit mode 0, 8-bit mode 3 and 8-bit mode 0 slaves
module tb_spi_slave_sync;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic sclk [3];
    logic cs_n [3];
    logic mosi [3];
    logic miso_w [3];
    logic oe_w [3];
    logic ovr_w [3];
    logic und_w [3];
    logic ferr_w [3];
    logic [127:0] tx_data_b [3];
    logic tx_valid_b [3];
    logic rx_ready_b [3];
    logic [127:0] rxd [3];
    logic rxv [3];
    logic txr [3];
    logic cpol_m [3] = '{1'b0, 1'b1, 1'b0};
    logic cpha_m [3] = '{1'b0, 1'b1, 1'b0};

    spi_slave_sync_if #(.WIDTH(64)) if0 ();
    spi_slave_sync_if #(.WIDTH(8))  if1 ();
    spi_slave_sync_if #(.WIDTH(8))  if2 ();

    assign if0.tx_data = tx_data_b[0][63:0];
    assign if1.tx_data = tx_data_b[1][7:0];
    assign if2.tx_data = tx_data_b[2][7:0];
    assign if0.tx_valid = tx_valid_b[0];
    assign if1.tx_valid = tx_valid_b[1];
    assign if2.tx_valid = tx_valid_b[2];
    assign if0.rx_ready = rx_ready_b[0];
    assign if1.rx_ready = rx_ready_b[1];
    assign if2.rx_ready = rx_ready_b[2];
    assign rxd[0] = 128'(if0.rx_data);
    assign rxd[1] = 128'(if1.rx_data);
    assign rxd[2] = 128'(if2.rx_data);
    assign rxv[0] = if0.rx_valid;
    assign rxv[1] = if1.rx_valid;
    assign rxv[2] = if2.rx_valid;
    assign txr[0] = if0.tx_ready;
    assign txr[1] = if1.tx_ready;
    assign txr[2] = if2.tx_ready;

    spi_slave_sync #(.WIDTH(64), .CPOL(0), .CPHA(0)) u_m0 (
        .clk(clk), .rst(rst), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
        .miso(miso_w[0]), .miso_oe(oe_w[0]), .overrun(ovr_w[0]), .underrun(und_w[0]),
        .frame_err(ferr_w[0]), .bus(if0.slave));
    spi_slave_sync #(.WIDTH(8), .CPOL(1), .CPHA(1)) u_m3 (
        .clk(clk), .rst(rst), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
        .miso(miso_w[1]), .miso_oe(oe_w[1]), .overrun(ovr_w[1]), .underrun(und_w[1]),
        .frame_err(ferr_w[1]), .bus(if1.slave));
    spi_slave_sync #(.WIDTH(8), .CPOL(0), .CPHA(0)) u_b8 (
        .clk(clk), .rst(rst), .sclk(sclk[2]), .cs_n(cs_n[2]), .mosi(mosi[2]),
        .miso(miso_w[2]), .miso_oe(oe_w[2]), .overrun(ovr_w[2]), .underrun(und_w[2]),
        .frame_err(ferr_w[2]), .bus(if2.slave));

    // Event monitor: words are counted on rx_valid rising, pulses once per cycle.
    int n_words [3];
    int n_ovr [3];
    int n_und [3];
    int n_ferr [3];
    logic [127:0] rx_hist [3][4];
    bit p_rxv [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rxv[i] && !p_rxv[i]) begin
                rx_hist[i][n_words[i][1:0]] <= rxd[i];
                n_words[i] <= n_words[i] + 1;
            end
            if (ovr_w[i])  n_ovr[i]  <= n_ovr[i] + 1;
            if (und_w[i])  n_und[i]  <= n_und[i] + 1;
            if (ferr_w[i]) n_ferr[i] <= n_ferr[i] + 1;
            p_rxv[i] <= rxv[i];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int s_w, s_o, s_u, s_f;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap(input int idx);
        s_w = n_words[idx];
        s_o = n_ovr[idx];
        s_u = n_und[idx];
        s_f = n_ferr[idx];
    endtask

    task automatic push_tx(input int idx, input logic [127:0] d);
        tx_data_b[idx]  = d;
        tx_valid_b[idx] = 1'b1;
        wait_clk(1);
        tx_valid_b[idx] = 1'b0;
    endtask

    task automatic frame_begin(input int idx);
        cs_n[idx] = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic frame_end(input int idx);
        wait_clk(HALF);
        cs_n[idx] = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic spi_bits(input int idx, input int nbits, input logic [127:0] mo,
                            output logic [127:0] mi);
        mi = '0;
        for (int b = nbits - 1; b >= 0; b--) begin
            if (!cpha_m[idx]) begin
                mosi[idx] = mo[b];
                wait_clk(HALF);
                sclk[idx] = !cpol_m[idx];
                mi = {mi[126:0], miso_w[idx]};
                wait_clk(HALF);
                sclk[idx] = cpol_m[idx];
            end else begin
                sclk[idx] = !cpol_m[idx];
                mosi[idx] = mo[b];
                wait_clk(HALF);
                sclk[idx] = cpol_m[idx];
                mi = {mi[126:0], miso_w[idx]};
                wait_clk(HALF);
            end
        end
    endtask

    typedef struct {
        bit         pre;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t vecs [5];

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] m1, m2;
        vecs[0] = '{1'b1, 8'h5A, 8'hC3, 8'h5A, 0};
        vecs[1] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 0};
        vecs[2] = '{1'b1, 8'h80, 8'h01, 8'h80, 0};
        vecs[3] = '{1'b0, 8'hA7, 8'h96, 8'h00, 1};
        vecs[4] = '{1'b1, 8'h3C, 8'hFF, 8'h3C, 0};

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sclk[i] = cpol_m[i];
            cs_n[i] = 1'b1;
            mosi[i] = 1'b0;
            tx_data_b[i] = '0;
            tx_valid_b[i] = 1'b0;
            rx_ready_b[i] = 1'b1;
        end
        wait_clk(5);
        chk("reset miso", 128'(miso_w[0]), 0);
        chk("reset miso_oe", 128'(oe_w[0]), 0);
        chk("reset tx_ready", 128'(txr[0]), 1);
        chk("reset rx_valid", 128'(rxv[0]), 0);
        chk("reset rx_data", rxd[0], 0);
        chk("reset mode3 miso", 128'(miso_w[1]), 0);
        rst = 1'b0;
        wait_clk(4);

        // 64-bit mode 0 word
        push_tx(0, 128'hDEADBEEF_01234567);
        snap(0);
        frame_begin(0);
        chk("m0 miso_oe active", 128'(oe_w[0]), 1);
        spi_bits(0, 64, 128'hA5A5_0F0F_5A5A_F0F0, m1);
        frame_end(0);
        chk("m0 miso stream", m1, 128'hDEADBEEF_01234567);
        chk("m0 rx_data", rxd[0], 128'hA5A5_0F0F_5A5A_F0F0);
        chk("m0 rx_valid count", 128'(n_words[0] - s_w), 1);
        chk("m0 underrun count", 128'(n_und[0] - s_u), 0);
        chk("m0 miso_oe idle", 128'(oe_w[0]), 0);

        // 8-bit mode 3, two words in one frame
        push_tx(1, 128'h81);
        snap(1);
        frame_begin(1);
        chk("m3 tx_ready after load", 128'(txr[1]), 1);
        push_tx(1, 128'h7E);
        chk("m3 tx_ready full", 128'(txr[1]), 0);
        spi_bits(1, 8, 128'h3C, m1);
        spi_bits(1, 8, 128'hC3, m2);
        frame_end(1);
        chk("m3 miso word0", m1, 128'h81);
        chk("m3 miso word1", m2, 128'h7E);
        chk("m3 rx count", 128'(n_words[1] - s_w), 2);
        chk("m3 rx word0", rx_hist[1][s_w % 4], 128'h3C);
        chk("m3 rx word1", rx_hist[1][(s_w + 1) % 4], 128'hC3);
        chk("m3 tx_ready end", 128'(txr[1]), 1);
        chk("m3 underrun count", 128'(n_und[1] - s_u), 0);

        // 8-bit mode 0 single-word table
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].pre) push_tx(2, 128'(vecs[v].tx));
            snap(2);
            frame_begin(2);
            spi_bits(2, 8, 128'(vecs[v].mo), m1);
            frame_end(2);
            chk($sformatf("vec%0d miso", v), m1, 128'(vecs[v].exp_miso));
            chk($sformatf("vec%0d rx_data", v), rxd[2], 128'(vecs[v].mo));
            chk($sformatf("vec%0d rx count", v), 128'(n_words[2] - s_w), 1);
            chk($sformatf("vec%0d underrun", v), 128'(n_und[2] - s_u), 128'(vecs[v].exp_und));
        end

        // overrun: rx_ready low across two words
        rx_ready_b[2] = 1'b0;
        snap(2);
        frame_begin(2);
        spi_bits(2, 8, 128'h11, m1);
        spi_bits(2, 8, 128'h22, m2);
        frame_end(2);
        chk("ovr rx_data", rxd[2], 128'h11);
        chk("ovr pulses", 128'(n_ovr[2] - s_o), 1);
        chk("ovr rx_valid held", 128'(rxv[2]), 1);
        chk("ovr rx count", 128'(n_words[2] - s_w), 1);
        rx_ready_b[2] = 1'b1;
        wait_clk(2);
        chk("ovr rx_valid drained", 128'(rxv[2]), 0);

        // frame error after 5 bits, then a clean frame
        snap(2);
        frame_begin(2);
        spi_bits(2, 5, 128'h16, m1);
        frame_end(2);
        chk("ferr pulses", 128'(n_ferr[2] - s_f), 1);
        chk("ferr no word", 128'(n_words[2] - s_w), 0);
        push_tx(2, 128'h69);
        frame_begin(2);
        spi_bits(2, 8, 128'hB4, m1);
        frame_end(2);
        chk("ferr next rx", rxd[2], 128'hB4);
        chk("ferr next miso", m1, 128'h69);
        chk("ferr no extra", 128'(n_ferr[2] - s_f), 1);

        // reset after 30 bits of a 64-bit frame
        push_tx(0, 128'hDEADBEEF_01234567);
        snap(0);
        frame_begin(0);
        spi_bits(0, 30, 128'h2AAA_AAAA, m1);
        rst = 1'b1;
        wait_clk(1);
        chk("rst miso", 128'(miso_w[0]), 0);
        chk("rst miso_oe", 128'(oe_w[0]), 0);
        chk("rst rx_valid", 128'(rxv[0]), 0);
        chk("rst tx_ready", 128'(txr[0]), 1);
        chk("rst rx_data", rxd[0], 0);
        chk("rst pulses", 128'({ovr_w[0], und_w[0], ferr_w[0]}), 0);
        cs_n[0] = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(6);
        chk("rst no frame_err", 128'(n_ferr[0] - s_f), 0);
        chk("rst stays idle", 128'(oe_w[0]), 0);
        push_tx(0, 128'h01234567_89ABCDEF);
        snap(0);
        frame_begin(0);
        spi_bits(0, 64, 128'hFEDCBA98_76543210, m1);
        frame_end(0);
        chk("post-rst miso", m1, 128'h01234567_89ABCDEF);
        chk("post-rst rx_data", rxd[0], 128'hFEDCBA98_76543210);
        chk("post-rst rx count", 128'(n_words[0] - s_w), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
